// File: rtl/data_mem.sv
// 256-byte big-endian data memory: combinational loads, clocked stores, async reset image.
// Define DATAMEM_PRELOAD_EN to seed M[20..23]=8'h55 and M[40..43]=8'hAA on reset.
module data_mem (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [1:0]  MemWrite,
   input  logic [1:0]  MemRead,
   output logic [31:0] ReadData
);

`ifdef DATAMEM_PRELOAD_EN
   localparam bit PreloadEn = 1'b1;
`else
   localparam bit PreloadEn = 1'b0;
`endif

   logic [7:0] mem_q [256];
   logic [7:0] addr;
   logic [7:0] lane_addr [4];
   logic [7:0] lane_data [4];
   logic [3:0] lane_en;
   logic [7:0] rd_byte [4];
   logic       unused_addr;

   assign addr        = Address[7:0];
   assign unused_addr = ^Address[31:8];

   function automatic logic [7:0] reset_byte(input int unsigned idx);
      logic [7:0] b;
      b = 8'h00;
      if (PreloadEn) begin
         if (idx >= 20 && idx <= 23) b = 8'h55;
         if (idx >= 40 && idx <= 43) b = 8'hAA;
      end
      return b;
   endfunction

   // Lane k targets byte A+k (mod 256); lane 0 carries the most significant stored byte.
   always_comb begin
      lane_en = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = addr + 8'(k);
         lane_data[k] = 8'h00;
      end
      unique case (MemWrite)
         2'b01: begin
            lane_en      = 4'b1111;
            lane_data[0] = WriteData[31:24];
            lane_data[1] = WriteData[23:16];
            lane_data[2] = WriteData[15:8];
            lane_data[3] = WriteData[7:0];
         end
         2'b10: begin
            lane_en      = 4'b0011;
            lane_data[0] = WriteData[15:8];
            lane_data[1] = WriteData[7:0];
         end
         2'b11: begin
            lane_en      = 4'b0001;
            lane_data[0] = WriteData[7:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) begin
            mem_q[i] <= reset_byte(i);
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) mem_q[lane_addr[k]] <= lane_data[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_byte[k] = mem_q[lane_addr[k]];
      end
      unique case (MemRead)
         2'b01:   ReadData = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
         2'b10:   ReadData = {16'h0000, rd_byte[0], rd_byte[1]};
         2'b11:   ReadData = {24'h000000, rd_byte[0]};
         default: ReadData = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; expectations follow DATAMEM_PRELOAD_EN.
module tb_data_mem;

`ifdef DATAMEM_PRELOAD_EN
   localparam logic [31:0] W55  = 32'h5555_5555;
   localparam logic [31:0] WAA  = 32'hAAAA_AAAA;
   localparam logic [31:0] W28B = 32'hAAEE_AAAA;
`else
   localparam logic [31:0] W55  = 32'h0000_0000;
   localparam logic [31:0] WAA  = 32'h0000_0000;
   localparam logic [31:0] W28B = 32'h00EE_0000;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [1:0]  MemWrite;
   logic [1:0]  MemRead;
   logic [31:0] ReadData;

   int unsigned err_cnt = 0;
   int unsigned chk_cnt = 0;

   data_mem u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic do_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemRead   = 2'b00;
      MemWrite  = size;
      Address   = a;
      WriteData = d;
      @(posedge clk);
      #1;
      MemWrite = 2'b00;
   endtask

   task automatic rd_check(input string tag, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] exp);
      @(negedge clk);
      MemRead = size;
      Address = a;
      #1;
      check(tag, ReadData, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      Address   = 32'h0000_0014;
      WriteData = 32'h0;
      MemWrite  = 2'b00;
      MemRead   = 2'b01;
      #2;
      check("rst_word14", ReadData, W55);

      // Store attempted while reset is held must be dropped
      @(negedge clk);
      MemWrite  = 2'b01;
      WriteData = 32'h1234_5678;
      @(posedge clk);
      #1;
      check("rst_store_ignored", ReadData, W55);
      MemWrite = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      rd_check("word14", 2'b01, 32'h0000_0014, W55);
      rd_check("word28_upper", 2'b01, 32'h2828_2828, WAA);
      rd_check("read_none", 2'b00, 32'h0000_0014, 32'h0);

      // Simultaneous read and write: old data before the edge, new data after
      @(negedge clk);
      MemRead   = 2'b01;
      MemWrite  = 2'b01;
      Address   = 32'h1414_1414;
      WriteData = 32'h9999_9999;
      #1;
      check("pre_store", ReadData, W55);
      @(posedge clk);
      #1;
      check("post_store", ReadData, 32'h9999_9999);
      MemWrite = 2'b00;
      rd_check("word14_new", 2'b01, 32'h0000_0014, 32'h9999_9999);
      rd_check("word28_kept", 2'b01, 32'h0000_0028, WAA);

      do_store(2'b11, 32'h0000_0029, 32'h1234_56EE);
      rd_check("byte_store_word", 2'b01, 32'h0000_0028, W28B);
      rd_check("byte_read29", 2'b11, 32'h0000_0029, 32'h0000_00EE);

      do_store(2'b10, 32'h0000_0000, 32'hDEAD_BEEF);
      rd_check("half_read0", 2'b10, 32'h0000_0000, 32'h0000_BEEF);
      rd_check("half_word0", 2'b01, 32'h0000_0000, 32'hBEEF_0000);

      do_store(2'b01, 32'h0000_00FE, 32'h0102_0304);
      rd_check("wrap_bFE", 2'b11, 32'h0000_00FE, 32'h0000_0001);
      rd_check("wrap_bFF", 2'b11, 32'h0000_00FF, 32'h0000_0002);
      rd_check("wrap_b00", 2'b11, 32'h0000_0000, 32'h0000_0003);
      rd_check("wrap_b01", 2'b11, 32'h0000_0001, 32'h0000_0004);
      rd_check("wrap_wFE", 2'b01, 32'h0000_00FE, 32'h0102_0304);
      rd_check("wrap_hFF", 2'b10, 32'h0000_00FF, 32'h0000_0203);
      rd_check("wrap_w00", 2'b01, 32'h0000_0000, 32'h0304_0000);

      do_store(2'b00, 32'h0000_00FE, 32'hFFFF_FFFF);
      rd_check("no_store", 2'b01, 32'h0000_00FE, 32'h0102_0304);

      // Asynchronous reset mid-cycle restores the image with no clock edge
      rd_check("pre_rst14", 2'b01, 32'h0000_0014, 32'h9999_9999);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst14", ReadData, W55);
      MemRead = 2'b01;
      Address = 32'h0000_00FE;
      #1;
      check("async_rstFE", ReadData, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_check("post_rst28", 2'b01, 32'h0000_0028, WAA);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
